uart_echo: RTL and testbench

Byte-level UART responder between `uart_rx` and `uart_tx`. It buffers every byte received from `uart_rx` in a FIFO, optionally folds lowercase ASCII to uppercase, and replays the bytes through `uart_tx` one at a time using that module's data-valid/done handshake. It provides the echo/response path for the serial link: bytes written by the far end come back on the transmit line, in order.

---
 rtl/uart_echo.sv | 134 +++++++++++++
 tb/tb_uart_echo.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo.sv
`timescale 1ns/1ps
// uart_echo: byte echo path between uart_rx and uart_tx.
// Received bytes are queued in a power-of-two FIFO, optionally folded to
// uppercase on the way in, and replayed to uart_tx one byte at a time.
//
// Handshake: o_tx_dv is a one-cycle request to uart_tx. o_tx_byte holds
// from that request until the next one. uart_tx acknowledges with a
// one-cycle i_tx_done. A done is consumed only while a request is
// outstanding (after the request cycle). One idle cycle follows each done
// so uart_tx can settle, which makes the next request land three cycles
// after the done.
module uart_echo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter bit UPPERCASE    = 1'b1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_rx_dv,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_tx_done,
  output logic              o_tx_dv,
  output logic [7:0]        o_tx_byte,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_busy
);

  // CLKS_PER_BIT only travels alongside this block to the serial engines;
  // it is checked here together with the FIFO geometry.
  generate
    if ((CLKS_PER_BIT < 1) || (DEPTH < 2) || (DEPTH != (1 << ADDR_W))) begin : g_bad_params
      $error("uart_echo: DEPTH must equal 2**ADDR_W (>=2) and CLKS_PER_BIT must be positive");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            full;
  logic            empty;
  logic            push;
  logic [7:0]      rx_folded;

  // Pointers carry one extra wrap bit: equal means empty, equal except
  // for the wrap bit means full.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  // Full is judged on the pre-edge pointers, so a push at full is dropped
  // even when a pop happens on the same edge.
  assign push    = i_rx_dv && !full;
  assign o_count = wr_ptr - rd_ptr;

  // Fold lowercase ASCII to uppercase before the byte enters the FIFO.
  always_comb begin
    rx_folded = i_rx_byte;
    if (UPPERCASE && (i_rx_byte >= 8'h61) && (i_rx_byte <= 8'h7A)) begin
      rx_folded = i_rx_byte - 8'h20;
    end
  end

  // FIFO storage; no reset needed since the pointers define what is valid.
  always_ff @(posedge i_clock) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= rx_folded;
    end
  end

  // Write pointer and sticky overflow flag.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (i_rx_dv && full) begin
        o_overflow <= 1'b1;
      end
    end
  end

  // Transmit sequencer: pop the head in IDLE, pulse the request in SEND,
  // wait for done, then spend one GAP cycle before looking at the FIFO again.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      rd_ptr    <= '0;
      o_tx_dv   <= 1'b0;
      o_tx_byte <= 8'h00;
      o_busy    <= 1'b0;
    end else begin
      o_tx_dv <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            o_tx_byte <= mem[rd_ptr[ADDR_W-1:0]];
            rd_ptr    <= rd_ptr + 1'b1;
            o_tx_dv   <= 1'b1;
            o_busy    <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_tx_done) begin
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo.sv
`timescale 1ns/1ps
// tb_uart_echo: directed bench for uart_echo with a queue-based reference,
// a behavioural serial transmitter/receiver pair standing in for uart_tx,
// and a second instance with case folding disabled.
module tb_uart_echo;

  localparam int CPB    = 87;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #50 clk = ~clk;  // 100 ns clock: 87 clocks = 8700 ns bit period

  // ---------------- DUT signals ----------------
  logic              rx_dv   = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              tx_done = 1'b0;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              busy;

  logic              fold_phase = 1'b0;
  logic              u1_rx_dv;
  logic              u1_done = 1'b0;
  logic              u1_tx_dv;
  logic [7:0]        u1_tx_byte;
  logic [ADDR_W:0]   u1_count;
  logic              u1_overflow;
  logic              u1_busy;
  assign u1_rx_dv = rx_dv & fold_phase;

  uart_echo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .UPPERCASE(1'b1)) dut (
    .i_clock(clk), .i_reset(rst), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
    .i_tx_done(tx_done), .o_tx_dv(tx_dv), .o_tx_byte(tx_byte),
    .o_count(count), .o_overflow(overflow), .o_busy(busy)
  );

  uart_echo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .UPPERCASE(1'b0)) dut_raw (
    .i_clock(clk), .i_reset(rst), .i_rx_dv(u1_rx_dv), .i_rx_byte(rx_byte),
    .i_tx_done(u1_done), .o_tx_dv(u1_tx_dv), .o_tx_byte(u1_tx_byte),
    .o_count(u1_count), .o_overflow(u1_overflow), .o_busy(u1_busy)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  // ---------------- reference model state ----------------
  logic [7:0]      mq[$];      // bytes held in the FIFO
  logic [7:0]      exp_q[$];   // bytes expected on the serial line
  logic [7:0]      got_q[$];   // bytes seen at o_tx_dv (main instance)
  logic [7:0]      got1_q[$];  // bytes seen at o_tx_dv (no-fold instance)
  int              cyc = 0;
  int              idle_from = 0;
  int              dv_cyc = 0;
  int              done_cyc = 0;
  int              push_cyc = 0;
  bit              in_flight = 1'b0;
  bit              spacing_armed = 1'b0;
  bit              push_armed = 1'b0;
  logic            exp_dv = 1'b0;
  logic [7:0]      exp_byte = 8'h00;
  logic [ADDR_W:0] exp_count = '0;
  logic            exp_ovf = 1'b0;
  logic            exp_busy = 1'b0;
  int              max_count = 0;
  int              dv_total = 0;
  bit              hold_done = 1'b0;

  function automatic logic [7:0] fold(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

  // Reference: FIFO as a queue; a byte may leave once the transmitter has
  // been idle since two cycles after the last done, and goes out on the
  // cycle after it leaves.
  initial begin
    int  c;
    bit  was_full;
    bit  do_pop;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        exp_q.delete();
        in_flight     = 1'b0;
        idle_from     = 0;
        spacing_armed = 1'b0;
        exp_dv        = 1'b0;
        exp_byte      = 8'h00;
        exp_count     = '0;
        exp_ovf       = 1'b0;
        exp_busy      = 1'b0;
      end else begin
        c        = cyc;
        was_full = (mq.size() == DEPTH);
        do_pop   = !in_flight && (c >= idle_from) && (mq.size() > 0);
        if (in_flight && tx_done && (c > dv_cyc)) begin
          in_flight     = 1'b0;
          idle_from     = c + 2;
          done_cyc      = c;
          spacing_armed = (mq.size() > 0);
        end
        exp_dv = 1'b0;
        if (do_pop) begin
          exp_byte  = mq.pop_front();
          exp_q.push_back(exp_byte);
          exp_dv    = 1'b1;
          in_flight = 1'b1;
          dv_cyc    = c + 1;
        end
        if (rx_dv) begin
          if (was_full) exp_ovf = 1'b1;
          else          mq.push_back(fold(rx_byte));
        end
        exp_count = ADDR_W'(0) + (ADDR_W+1)'(mq.size());
        exp_busy  = in_flight || ((c + 1) < idle_from);
      end
      cyc = cyc + 1;
    end
  end

  // Per-cycle compare of every output against the reference.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        tests++;
        if ({tx_dv, tx_byte, count, overflow, busy} !==
            {exp_dv, exp_byte, exp_count, exp_ovf, exp_busy}) begin
          fails++;
          $display("FAIL cycle_compare cyc=%0d got dv=%b byte=%h count=%0d ovf=%b busy=%b want dv=%b byte=%h count=%0d ovf=%b busy=%b",
                   cyc, tx_dv, tx_byte, count, overflow, busy,
                   exp_dv, exp_byte, exp_count, exp_ovf, exp_busy);
        end
        if (tx_dv) begin
          got_q.push_back(tx_byte);
          dv_total++;
          if (spacing_armed) begin
            tests++;
            if (cyc - done_cyc != 3) begin
              fails++;
              $display("FAIL done_to_dv_spacing got=%0d want=3", cyc - done_cyc);
            end
            spacing_armed = 1'b0;
          end
          if (push_armed) begin
            tests++;
            if (cyc - push_cyc != 2) begin
              fails++;
              $display("FAIL push_to_dv_latency got=%0d want=2", cyc - push_cyc);
            end
            push_armed = 1'b0;
          end
        end
        if (int'(count) > max_count) max_count = int'(count);
        if (u1_tx_dv) got1_q.push_back(u1_tx_byte);
      end
    end
  end

  // Stand-in for uart_tx (serialiser + done pulse), a serial receiver that
  // checks the line against the expected bytes, and a quick responder for
  // the no-fold instance.
  initial begin
    bit         tx_active = 1'b0;
    bit         done_pend = 1'b0;
    int         tx_cnt = 0;
    logic [9:0] tx_frame = '1;
    logic       tx_serial = 1'b1;
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    int         bi;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] e;
    int         u1_wait = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_active = 1'b0;
        done_pend = 1'b0;
        tx_done   = 1'b0;
        tx_serial = 1'b1;
        rx_busy   = 1'b0;
        u1_done   = 1'b0;
        u1_wait   = 0;
      end else begin
        tx_done = 1'b0;
        if (done_pend && !hold_done) begin
          tx_done   = 1'b1;
          done_pend = 1'b0;
        end
        if (tx_active) begin
          tx_serial = tx_frame[tx_cnt / CPB];
          tx_cnt++;
          if (tx_cnt == 10 * CPB) begin
            tx_active = 1'b0;
            done_pend = 1'b1;
          end
        end else begin
          tx_serial = 1'b1;
        end
        if (tx_dv) begin
          tx_active = 1'b1;
          tx_cnt    = 0;
          tx_frame  = {1'b1, tx_byte, 1'b0};
        end
        if (!rx_busy) begin
          if (tx_serial == 1'b0) begin
            rx_busy = 1'b1;
            rx_cnt  = 0;
          end
        end else begin
          rx_cnt++;
          if (rx_cnt % CPB == CPB / 2) begin
            bi = rx_cnt / CPB;
            if (bi >= 1 && bi <= 8) begin
              rx_sh[bi-1] = tx_serial;
            end else if (bi == 9) begin
              rx_busy = 1'b0;
              tests++;
              if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL serial_echo got=%h want=<none>", rx_sh);
              end else begin
                e = exp_q.pop_front();
                if (rx_sh !== e || tx_serial !== 1'b1) begin
                  fails++;
                  $display("FAIL serial_echo got=%h stop=%b want=%h stop=1", rx_sh, tx_serial, e);
                end
              end
            end
          end
        end
        u1_done = 1'b0;
        if (u1_wait > 0) begin
          u1_wait--;
          if (u1_wait == 0) u1_done = 1'b1;
        end
        if (u1_tx_dv) u1_wait = 6;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic check_seq(input string name, input logic [7:0] want[$], input logic [7:0] got[$]);
    check({name, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++) begin
      check(name, {24'h0, got[i]}, {24'h0, want[i]});
    end
  endtask

  task automatic push_burst(input logic [7:0] bytes[$]);
    for (int i = 0; i < bytes.size(); i++) begin
      rx_byte = bytes[i];
      rx_dv   = 1'b1;
      @(negedge clk);
    end
    rx_dv = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((mq.size() != 0 || in_flight || cyc < idle_from) && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= budget) begin
      fails++;
      $display("FAIL wait_idle_timeout got=%0d cycles want<%0d", n, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] bytes[$];
    logic [7:0] want[$];
    int         n;
    int         dv_snap;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx_dv",    {31'h0, tx_dv},    32'h0);
    check("reset_tx_byte",  {24'h0, tx_byte},  32'h0);
    check("reset_count",    {27'h0, count},    32'h0);
    check("reset_overflow", {31'h0, overflow}, 32'h0);
    check("reset_busy",     {31'h0, busy},     32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte: one request two cycles after the strobe.
    got_q.delete();
    rx_byte    = 8'h3F;
    rx_dv      = 1'b1;
    push_cyc   = cyc;
    push_armed = 1'b1;
    @(negedge clk);
    rx_dv = 1'b0;
    wait_idle(1200);
    want.delete(); want.push_back(8'h3F);
    check_seq("single_byte", want, got_q);
    check("single_busy_after",  {31'h0, busy},  32'h0);
    check("single_count_after", {27'h0, count}, 32'h0);

    // Case fold, with and without UPPERCASE.
    got_q.delete();
    got1_q.delete();
    fold_phase = 1'b1;
    bytes.delete();
    bytes.push_back(8'h61); bytes.push_back(8'h7A); bytes.push_back(8'h7B); bytes.push_back(8'h41);
    push_burst(bytes);
    fold_phase = 1'b0;
    wait_idle(4 * 900 + 200);
    want.delete();
    want.push_back(8'h41); want.push_back(8'h5A); want.push_back(8'h7B); want.push_back(8'h41);
    check_seq("fold_upper", want, got_q);
    want.delete();
    want.push_back(8'h61); want.push_back(8'h7A); want.push_back(8'h7B); want.push_back(8'h41);
    check_seq("fold_raw", want, got1_q);

    // Burst of 16 back-to-back bytes: ordered, no overflow.
    got_q.delete();
    max_count = 0;
    bytes.delete();
    for (int i = 0; i < 16; i++) bytes.push_back(8'(i));
    push_burst(bytes);
    tests++;
    if (!(max_count == 15 || max_count == 16)) begin
      fails++;
      $display("FAIL burst_peak_count got=%0d want=15..16", max_count);
    end
    wait_idle(16 * 900 + 200);
    check_seq("burst_order", bytes, got_q);
    check("burst_overflow", {31'h0, overflow}, 32'h0);

    // Overflow: 18 back-to-back bytes with done held off.
    got_q.delete();
    hold_done = 1'b1;
    bytes.delete();
    for (int i = 0; i < 18; i++) bytes.push_back(8'h80 + 8'(i));
    push_burst(bytes);
    @(negedge clk);
    check("ovf_count_full", {27'h0, count},    32'd16);
    check("ovf_flag",       {31'h0, overflow}, 32'h1);
    repeat (1000) @(negedge clk);
    check("ovf_count_held", {27'h0, count},    32'd16);
    check("ovf_busy_held",  {31'h0, busy},     32'h1);
    hold_done = 1'b0;
    wait_idle(17 * 900 + 200);
    want.delete();
    for (int i = 0; i < 17; i++) want.push_back(8'h80 + 8'(i));
    check_seq("ovf_drain", want, got_q);
    check("ovf_flag_sticky", {31'h0, overflow}, 32'h1);

    // Reset during WAIT with five bytes queued.
    got_q.delete();
    bytes.delete();
    for (int i = 0; i < 6; i++) bytes.push_back(8'h30 + 8'(i));
    push_burst(bytes);
    n = 0;
    while (got_q.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_first_dv_seen", {31'h0, (got_q.size() != 0)}, 32'h1);
    repeat (20) @(negedge clk);
    check("rst_queued", {27'h0, count}, 32'd5);
    rst = 1'b1;
    #1;
    check("rst_mid_tx_dv",    {31'h0, tx_dv},    32'h0);
    check("rst_mid_tx_byte",  {24'h0, tx_byte},  32'h0);
    check("rst_mid_count",    {27'h0, count},    32'h0);
    check("rst_mid_overflow", {31'h0, overflow}, 32'h0);
    check("rst_mid_busy",     {31'h0, busy},     32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    dv_snap = dv_total;
    repeat (60) @(negedge clk);
    check("rst_no_dv_after", dv_total - dv_snap, 32'h0);
    got_q.delete();
    rx_byte    = 8'h55;
    rx_dv      = 1'b1;
    push_cyc   = cyc;
    push_armed = 1'b1;
    @(negedge clk);
    rx_dv = 1'b0;
    wait_idle(1200);
    want.delete(); want.push_back(8'h55);
    check_seq("rst_new_byte", want, got_q);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog: the directed sequence needs well under this many cycles.
  initial begin
    repeat (95000) @(posedge clk);
    fails++;
    $display("FAIL watchdog got=95000 cycles want=<95000");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
